// File: rtl/jtframe_uio_pkg.sv
// Shared constants and FSM encoding for the user-I/O SPI receiver.
package jtframe_uio_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_TXPARAM,
        ST_DATA,
        ST_INDEX
    } uio_state_t;

endpackage

// File: rtl/jtframe_uio_rxbyte.sv
// Oversampling SPI byte receiver: synchronises SCK/DI/SS2 into clk,
// detects SCK rising edges and assembles MSB-first bytes.
module jtframe_uio_rxbyte #(
    parameter int unsigned SYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       di,
    input  logic       ss2,
    output logic       byte_rdy,
    output logic [7:0] rx_byte,
    output logic       ss2_lvl
);

    logic [SYNC-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC-1:0] di_sync_q,  di_sync_d;
    logic [SYNC-1:0] ss2_sync_q, ss2_sync_d;
    logic            sck_prev_q, sck_prev_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            rdy_q, rdy_d;
    logic            sck_s, di_s, ss2_s, sck_rise;

    assign sck_s    = sck_sync_q[SYNC-1];
    assign di_s     = di_sync_q[SYNC-1];
    assign ss2_s    = ss2_sync_q[SYNC-1];
    assign sck_rise = sck_s & ~sck_prev_q;

    assign byte_rdy = rdy_q;
    assign rx_byte  = byte_q;
    assign ss2_lvl  = ss2_s;

    // Synchroniser shift, edge detect, bit shifting and byte completion.
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC-2:0], sck};
        di_sync_d  = {di_sync_q[SYNC-2:0], di};
        ss2_sync_d = {ss2_sync_q[SYNC-2:0], ss2};
        sck_prev_d = sck_s;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        rdy_d      = 1'b0;
        if (ss2_s) begin
            cnt_d   = 3'd0;
            shift_d = '0;
        end else if (sck_rise) begin
            shift_d = {shift_q[6:0], di_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                rdy_d  = 1'b1;
                byte_d = {shift_q[6:0], di_s};
            end
        end
    end

    // State registers; SS2 chain resets to the deselected level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= '0;
            di_sync_q  <= '0;
            ss2_sync_q <= '1;
            sck_prev_q <= 1'b0;
            cnt_q      <= 3'd0;
            shift_q    <= '0;
            byte_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            di_sync_q  <= di_sync_d;
            ss2_sync_q <= ss2_sync_d;
            sck_prev_q <= sck_prev_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            rdy_q      <= rdy_d;
        end
    end

endmodule

// File: rtl/jtframe_uio_rx.sv
// User-I/O SPI target receiver: decodes file-transfer commands and drives
// the ioctl download bus. Optional running byte sum: JTFRAME_UIO_SUM_EN.
module jtframe_uio_rx
    import jtframe_uio_pkg::*;
#(
    parameter int unsigned AW   = 22,
    parameter int unsigned SYNC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SPI_SCK,
    input  logic          SPI_DI,
    input  logic          SPI_SS2,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr,
    output logic [7:0]    ioctl_index,
    output logic          downloading,
    output logic          ioctl_ovf,
    output logic [15:0]   dwn_sum
);

    logic       byte_rdy;
    logic [7:0] rx_byte;
    logic       ss2_lvl;

    uio_state_t    state_q, state_d;
    logic          ss2_prev_q, ss2_prev_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    dout_q, dout_d;
    logic          wr_q, wr_d;
    logic [7:0]    index_q, index_d;
    logic          dl_q, dl_d;
    logic          ovf_q, ovf_d;
`ifdef JTFRAME_UIO_SUM_EN
    logic [15:0]   sum_q, sum_d;
`endif

    jtframe_uio_rxbyte #(.SYNC(SYNC)) u_rxbyte (
        .clk      (clk),
        .rst      (rst),
        .sck      (SPI_SCK),
        .di       (SPI_DI),
        .ss2      (SPI_SS2),
        .byte_rdy (byte_rdy),
        .rx_byte  (rx_byte),
        .ss2_lvl  (ss2_lvl)
    );

    assign ioctl_addr  = addr_q;
    assign ioctl_dout  = dout_q;
    assign ioctl_wr    = wr_q;
    assign ioctl_index = index_q;
    assign downloading = dl_q;
    assign ioctl_ovf   = ovf_q;
`ifdef JTFRAME_UIO_SUM_EN
    assign dwn_sum     = sum_q;
`else
    assign dwn_sum     = '0;
`endif

    // Command FSM and ioctl bus update; a completed byte wins over SS2 release.
    always_comb begin
        state_d    = state_q;
        ss2_prev_d = ss2_lvl;
        addr_d     = addr_q;
        dout_d     = dout_q;
        wr_d       = 1'b0;
        index_d    = index_q;
        dl_d       = dl_q;
        ovf_d      = ovf_q;
`ifdef JTFRAME_UIO_SUM_EN
        sum_d      = sum_q;
`endif
        if (wr_q) begin
            addr_d = addr_q + AW'(1);
            if (addr_d == '0) ovf_d = 1'b1;
`ifdef JTFRAME_UIO_SUM_EN
            sum_d = sum_q + {8'h00, dout_q};
`endif
        end
        if (byte_rdy) begin
            case (state_q)
                ST_CMD: begin
                    case (rx_byte)
                        UIO_FILE_TX:     state_d = ST_TXPARAM;
                        UIO_FILE_TX_DAT: state_d = ST_DATA;
                        UIO_FILE_INDEX:  state_d = ST_INDEX;
                        default:         state_d = ST_IDLE;
                    endcase
                end
                ST_TXPARAM: begin
                    if (rx_byte != 8'h00) begin
                        dl_d   = 1'b1;
                        addr_d = '0;
                        ovf_d  = 1'b0;
`ifdef JTFRAME_UIO_SUM_EN
                        sum_d  = '0;
`endif
                    end else begin
                        dl_d = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
                ST_INDEX: begin
                    index_d = rx_byte;
                    state_d = ST_IDLE;
                end
                ST_DATA: begin
                    if (dl_q) begin
                        dout_d = rx_byte;
                        wr_d   = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end else if (ss2_lvl) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE && ss2_prev_q) begin
            state_d = ST_CMD;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ss2_prev_q <= 1'b1;
            addr_q     <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
            index_q    <= '0;
            dl_q       <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef JTFRAME_UIO_SUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ss2_prev_q <= ss2_prev_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            index_q    <= index_d;
            dl_q       <= dl_d;
            ovf_q      <= ovf_d;
`ifdef JTFRAME_UIO_SUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule
